sample_play_ctrl: RTL

- Playback sequencer for the stereo sample ROMs (left/right, 16-bit, single-port, synchronous read).
- Replaces free-running one-sample-per-clock addressing with commanded play/stop, optional looping and a programmable sample-rate divider.
- Reads one stereo sample per sample period and presents it to the downstream audio serializer over a valid/ready handshake.
- Sits between the sample memories and the DAC/I2S output stage.

---
 rtl/sample_play_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/sample_play_ctrl.sv
// Playback sequencer for stereo sample ROMs: commanded play/stop, optional looping,
// one synchronous read per DIV-clock sample period, valid/ready output to the serializer.
module sample_play_ctrl #(
   parameter int ADDR_W = 19,
   parameter int DEPTH  = 384000,
   parameter int DIV    = 1250
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_play,
   input  logic              i_stop,
   input  logic              i_loop,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic              o_mem_en,
   input  logic [15:0]       i_mem_left,
   input  logic [15:0]       i_mem_right,
   output logic [15:0]       o_left,
   output logic [15:0]       o_right,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_underrun
);

   localparam int DIV_W = $clog2(DIV);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_REQ  = 2'd2,
      S_CAP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [DIV_W-1:0]  div_cnt;
   logic [DIV_W-1:0]  div_nx;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] addr_nx;
   logic [ADDR_W-1:0] addr_inc;
   logic              end_flag;
   logic              end_nx;
   logic              tick;
   logic              at_last;
   logic              stall;
   logic              rd_nx;
   logic              cap;
   logic              done_nx;
   logic              und_nx;

   assign tick     = (state == S_WAIT) && (div_cnt == DIV_W'(DIV - 1));
   assign at_last  = (addr == ADDR_W'(DEPTH - 1));
   assign addr_inc = at_last ? {ADDR_W{1'b0}} : addr + ADDR_W'(1);
   assign stall    = o_valid && !i_ready;

   // Next-state, divider, address and one-cycle strobe decode
   always_comb begin
      state_nx = state;
      div_nx   = div_cnt;
      addr_nx  = addr;
      end_nx   = end_flag;
      rd_nx    = 1'b0;
      cap      = 1'b0;
      done_nx  = 1'b0;
      und_nx   = 1'b0;

      if (state != S_IDLE) begin
         div_nx = (div_cnt == DIV_W'(DIV - 1)) ? {DIV_W{1'b0}} : div_cnt + DIV_W'(1);
      end else begin
         div_nx = {DIV_W{1'b0}};
      end

      case (state)
         S_IDLE: begin
            if (i_play) begin
               state_nx = S_WAIT;
               end_nx   = 1'b0;
            end else begin
               state_nx = S_IDLE;
            end
         end
         S_WAIT: begin
            if (tick && stall) begin
               // Sample period missed: skip this address but keep the timeline running
               und_nx  = 1'b1;
               addr_nx = addr_inc;
               if (at_last && !i_loop) begin
                  state_nx = S_IDLE;
                  done_nx  = 1'b1;
               end else begin
                  state_nx = S_WAIT;
               end
            end else if (tick) begin
               state_nx = S_REQ;
               rd_nx    = 1'b1;
            end else begin
               state_nx = S_WAIT;
            end
         end
         S_REQ: begin
            state_nx = S_CAP;
            addr_nx  = addr_inc;
            if (at_last && !i_loop) begin
               end_nx = 1'b1;
            end else begin
               end_nx = end_flag;
            end
         end
         S_CAP: begin
            cap = 1'b1;
            if (end_flag) begin
               state_nx = S_IDLE;
               done_nx  = 1'b1;
            end else begin
               state_nx = S_WAIT;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase

      if (i_stop) begin
         state_nx = S_IDLE;
         end_nx   = 1'b0;
         rd_nx    = 1'b0;
         cap      = 1'b0;
         done_nx  = 1'b0;
         und_nx   = 1'b0;
      end else begin
         end_nx = end_nx;
      end

      // Anything that lands in IDLE restarts the timeline from zero
      if (state_nx == S_IDLE) begin
         div_nx  = {DIV_W{1'b0}};
         addr_nx = {ADDR_W{1'b0}};
      end else begin
         addr_nx = addr_nx;
      end
   end

   // State, counters and all registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= S_IDLE;
         div_cnt    <= {DIV_W{1'b0}};
         addr       <= {ADDR_W{1'b0}};
         end_flag   <= 1'b0;
         o_mem_addr <= {ADDR_W{1'b0}};
         o_mem_en   <= 1'b0;
         o_left     <= 16'h0000;
         o_right    <= 16'h0000;
         o_valid    <= 1'b0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_underrun <= 1'b0;
      end else begin
         state      <= state_nx;
         div_cnt    <= div_nx;
         addr       <= addr_nx;
         end_flag   <= end_nx;
         o_mem_en   <= rd_nx;
         o_busy     <= (state_nx != S_IDLE);
         o_done     <= done_nx;
         o_underrun <= und_nx;
         if (rd_nx) begin
            o_mem_addr <= addr;
         end
         // A capture wins over acceptance so a new sample is never lost
         if (i_stop) begin
            o_valid <= 1'b0;
         end else if (cap) begin
            o_left  <= i_mem_left;
            o_right <= i_mem_right;
            o_valid <= 1'b1;
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
      end
   end

endmodule
